// File: rtl/adc_trig_decim_pkg.sv
// Shared types and helpers for the ADC trigger/decimation stage:
// FSM states, trigger mode encodings and the output sample packing.
package adc_trig_decim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [1:0] MODE_IMM  = 2'd0;
  localparam logic [1:0] MODE_RISE = 2'd1;
  localparam logic [1:0] MODE_FALL = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam int ADC_W = 12;

  function automatic logic [31:0] pack_sample(input logic [ADC_W-1:0] ch0,
                                              input logic [ADC_W-1:0] ch1);
    return {4'b0, ch0, 4'b0, ch1};
  endfunction

endpackage

// File: rtl/adc_trig_decim_if.sv
// Output bundle of adc_trig_decim towards the memory controller.
// The block drives it through the master modport; consumers use slave.
interface adc_trig_decim_if;
  import adc_trig_decim_pkg::*;

  logic [31:0] sample_o;
  logic        sample_vld_o;
  logic        triggered_o;
  logic [1:0]  state_o;
  logic [15:0] sample_cnt_o;

  modport master (output sample_o, sample_vld_o, triggered_o, state_o, sample_cnt_o);
  modport slave  (input  sample_o, sample_vld_o, triggered_o, state_o, sample_cnt_o);
endinterface

// File: rtl/adc_trig_decim_boxcar_decim.sv
// Boxcar averager over 2^k samples for one ADC channel; the averaged
// value and its one-cycle strobe are registered (pipeline stage 1).
module boxcar_decim
  import adc_trig_decim_pkg::*;
#(
  parameter int MAX_LOG2 = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [3:0]       log2_i,
  input  logic [ADC_W-1:0] din_i,
  output logic [ADC_W-1:0] avg_o,
  output logic             stb_o
);
  localparam int ACC_W = ADC_W + MAX_LOG2;
  localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;
  logic [ADC_W-1:0] avg_q, avg_d;
  logic             stb_q, stb_d;

  always_comb begin
    sum      = acc_q + ACC_W'(din_i);
    last_cnt = CNT_W'((32'd1 << log2_i) - 32'd1);
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    avg_d    = avg_q;
    stb_d    = 1'b0;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == last_cnt) begin
        // The closing sample is folded in here rather than stored first.
        avg_d = ADC_W'(sum >> log2_i);
        stb_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
      stb_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
      stb_q <= stb_d;
    end
  end

  assign avg_o = avg_q;
  assign stb_o = stb_q;
endmodule

// File: rtl/adc_trig_decim.sv
// Two-channel boxcar decimator with a hysteresis level trigger; the trigger
// FSM and output registers form pipeline stage 2.
module adc_trig_decim
  import adc_trig_decim_pkg::*;
#(
  parameter int MAX_LOG2 = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [ADC_W-1:0]  ad_data_ch0_i,
  input  logic [ADC_W-1:0]  ad_data_ch1_i,
  input  logic              arm_i,
  input  logic [3:0]        cfg_log2_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic              cfg_trig_ch_i,
  input  logic [ADC_W-1:0]  cfg_level_i,
  input  logic [ADC_W-1:0]  cfg_hyst_i,
  adc_trig_decim_if.master  out_if
);
  logic             arm_q, trig_ch_q, trig_ch_d, flag_q, flag_d;
  logic [3:0]       log2_q, log2_d, log2_clamped;
  logic [1:0]       mode_q, mode_d;
  logic [ADC_W-1:0] level_q, level_d, hyst_q, hyst_d;
  state_e           state_q, state_d;
  logic [31:0]      sample_q, sample_d;
  logic             vld_q, vld_d, trig_q, trig_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             arm_rise, decim_en, dec_stb, fire, flag_set, emit;
  logic [ADC_W-1:0] ch_din [2];
  logic [ADC_W-1:0] ch_avg [2];
  logic [1:0]       ch_stb;
  logic [ADC_W-1:0] trig_val, thr_lo, thr_hi;
  logic [ADC_W:0]   level_plus;

  assign arm_rise     = arm_i & ~arm_q;
  assign decim_en     = (state_q != ST_IDLE);
  assign dec_stb      = &ch_stb;
  assign log2_clamped = (32'(cfg_log2_i) > MAX_LOG2) ? 4'(MAX_LOG2) : cfg_log2_i;
  assign ch_din[0]    = ad_data_ch0_i;
  assign ch_din[1]    = ad_data_ch1_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    boxcar_decim #(.MAX_LOG2(MAX_LOG2)) u_decim (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clr_i     (arm_rise),
      .en_i      (decim_en),
      .log2_i    (log2_q),
      .din_i     (ch_din[gi]),
      .avg_o     (ch_avg[gi]),
      .stb_o     (ch_stb[gi])
    );
  end

  // Hysteresis thresholds saturate at the ends of the 12-bit range.
  always_comb begin
    level_plus = {1'b0, level_q} + {1'b0, hyst_q};
    thr_lo     = (level_q > hyst_q) ? (level_q - hyst_q) : '0;
    thr_hi     = level_plus[ADC_W] ? '1 : level_plus[ADC_W-1:0];
    trig_val   = trig_ch_q ? ch_avg[1] : ch_avg[0];
    fire       = 1'b0;
    flag_set   = 1'b0;
    if (mode_q == MODE_RISE) begin
      fire     = flag_q && (trig_val >= level_q);
      flag_set = (trig_val <= thr_lo);
    end else if (mode_q == MODE_FALL) begin
      fire     = flag_q && (trig_val <= level_q);
      flag_set = (trig_val >= thr_hi);
    end
  end

  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    log2_d    = log2_q;
    mode_d    = mode_q;
    trig_ch_d = trig_ch_q;
    level_d   = level_q;
    hyst_d    = hyst_q;
    sample_d  = sample_q;
    cnt_d     = cnt_q;
    vld_d     = 1'b0;
    trig_d    = 1'b0;
    emit      = 1'b0;
    if (!arm_i) begin
      state_d = ST_IDLE;
    end else if (arm_rise) begin
      log2_d    = log2_clamped;
      mode_d    = cfg_mode_i;
      trig_ch_d = cfg_trig_ch_i;
      level_d   = cfg_level_i;
      hyst_d    = cfg_hyst_i;
      flag_d    = 1'b0;
      cnt_d     = '0;
      state_d   = (cfg_mode_i == MODE_RISE || cfg_mode_i == MODE_FALL) ? ST_ARMED : ST_RUN;
    end else if (dec_stb) begin
      case (state_q)
        ST_ARMED: begin
          if (fire) begin
            emit    = 1'b1;
            state_d = ST_RUN;
          end else if (flag_set) begin
            flag_d = 1'b1;
          end
        end
        ST_RUN:  emit = 1'b1;
        default: emit = 1'b0;
      endcase
    end
    // Nothing is emitted before the trigger, so a zero count marks the first output.
    if (emit) begin
      vld_d    = 1'b1;
      trig_d   = (cnt_q == '0);
      sample_d = pack_sample(ch_avg[0], ch_avg[1]);
      cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      arm_q     <= 1'b0;
      state_q   <= ST_IDLE;
      flag_q    <= 1'b0;
      log2_q    <= '0;
      mode_q    <= MODE_IMM;
      trig_ch_q <= 1'b0;
      level_q   <= '0;
      hyst_q    <= '0;
      sample_q  <= '0;
      vld_q     <= 1'b0;
      trig_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      arm_q     <= arm_i;
      state_q   <= state_d;
      flag_q    <= flag_d;
      log2_q    <= log2_d;
      mode_q    <= mode_d;
      trig_ch_q <= trig_ch_d;
      level_q   <= level_d;
      hyst_q    <= hyst_d;
      sample_q  <= sample_d;
      vld_q     <= vld_d;
      trig_q    <= trig_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_if.sample_o     = sample_q;
  assign out_if.sample_vld_o = vld_q;
  assign out_if.triggered_o  = trig_q;
  assign out_if.state_o      = state_q;
  assign out_if.sample_cnt_o = cnt_q;
endmodule

// File: tb/tb_adc_trig_decim.sv
// Randomized directed bench for adc_trig_decim: each scenario is predicted
// window-by-window from the input history and compared cycle by cycle.
module tb_adc_trig_decim;
  logic        sys_clk;
  logic        sys_rst_n;
  logic [11:0] ad_data_ch0_i, ad_data_ch1_i;
  logic        arm_i;
  logic [3:0]  cfg_log2_i;
  logic [1:0]  cfg_mode_i;
  logic        cfg_trig_ch_i;
  logic [11:0] cfg_level_i, cfg_hyst_i;

  adc_trig_decim_if out_if ();

  adc_trig_decim #(.MAX_LOG2(8)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .ad_data_ch0_i (ad_data_ch0_i),
    .ad_data_ch1_i (ad_data_ch1_i),
    .arm_i         (arm_i),
    .cfg_log2_i    (cfg_log2_i),
    .cfg_mode_i    (cfg_mode_i),
    .cfg_trig_ch_i (cfg_trig_ch_i),
    .cfg_level_i   (cfg_level_i),
    .cfg_hyst_i    (cfg_hyst_i),
    .out_if        (out_if)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] in0 [0:1023];
  logic [11:0] in1 [0:1023];
  bit          exp_vld   [0:1023];
  bit          exp_trig  [0:1023];
  int          exp_state [0:1023];
  int          exp_cnt   [0:1023];
  logic [31:0] exp_sample[0:1023];

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, expv);
  endtask

  // Model: average whole windows, scan them for the trigger, then place each
  // emitted window two edges after its last contributing sample.
  task automatic run_scen(input string tag, input int k_cfg, input int mode, input int tch,
                          input int level, input int hyst, input int n, input int chg_at);
    int k, nw, fire, thr, v, cnt, s0, s1, c, nout;
    bit flag, fire_now, set_now;
    int avg0[$];
    int avg1[$];
    k  = (k_cfg > 8) ? 8 : k_cfg;
    nw = 1 << k;
    for (int j = 0; (j + 1) * nw <= n; j++) begin
      s0 = 0; s1 = 0;
      for (int i = j * nw; i < (j + 1) * nw; i++) begin
        s0 += int'(in0[i]);
        s1 += int'(in1[i]);
      end
      avg0.push_back(s0 >> k);
      avg1.push_back(s1 >> k);
    end
    fire = -1;
    if (mode == 1 || mode == 2) begin
      flag = 1'b0;
      for (int j = 0; j < avg0.size(); j++) begin
        v = (tch != 0) ? avg1[j] : avg0[j];
        if (mode == 1) begin
          thr = (level > hyst) ? level - hyst : 0;
          fire_now = flag && (v >= level);
          set_now  = (v <= thr);
        end else begin
          thr = (level + hyst > 4095) ? 4095 : level + hyst;
          fire_now = flag && (v <= level);
          set_now  = (v >= thr);
        end
        if (fire_now) begin
          fire = j;
          break;
        end
        if (set_now) flag = 1'b1;
      end
    end else begin
      fire = 0;
    end
    for (int i = 0; i <= n; i++) begin
      exp_vld[i]    = 1'b0;
      exp_trig[i]   = 1'b0;
      exp_sample[i] = '0;
      exp_state[i]  = (mode == 1 || mode == 2) ? 1 : 2;
    end
    if (fire >= 0) begin
      for (int j = fire; j < avg0.size(); j++) begin
        c = (j + 1) * nw + 1;
        if (c <= n) begin
          exp_vld[c]    = 1'b1;
          exp_trig[c]   = (j == fire);
          exp_sample[c] = {4'b0, 12'(avg0[j]), 4'b0, 12'(avg1[j])};
        end
      end
      for (int i = (fire + 1) * nw + 1; i <= n; i++) exp_state[i] = 2;
    end
    cnt = 0;
    nout = 0;
    for (int i = 0; i <= n; i++) begin
      if (exp_vld[i]) begin
        cnt = (cnt < 65535) ? cnt + 1 : cnt;
        nout++;
      end
      exp_cnt[i] = cnt;
    end

    @(negedge sys_clk);
    arm_i = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cfg_log2_i    = 4'(k_cfg);
    cfg_mode_i    = 2'(mode);
    cfg_trig_ch_i = 1'(tch);
    cfg_level_i   = 12'(level);
    cfg_hyst_i    = 12'(hyst);
    ad_data_ch0_i = 12'($urandom);
    ad_data_ch1_i = 12'($urandom);
    arm_i = 1'b1;
    @(posedge sys_clk);
    for (int i = 0; i <= n; i++) begin
      @(negedge sys_clk);
      chk({tag, "_vld"},   i, 32'(out_if.sample_vld_o), 32'(exp_vld[i]));
      chk({tag, "_trig"},  i, 32'(out_if.triggered_o),  32'(exp_trig[i]));
      chk({tag, "_state"}, i, 32'(out_if.state_o),      32'(exp_state[i]));
      chk({tag, "_cnt"},   i, 32'(out_if.sample_cnt_o), 32'(exp_cnt[i]));
      if (exp_vld[i]) chk({tag, "_sample"}, i, out_if.sample_o, exp_sample[i]);
      if (i < n) begin
        ad_data_ch0_i = in0[i];
        ad_data_ch1_i = in1[i];
        if (i == chg_at) begin
          cfg_log2_i  = 4'd4;
          cfg_mode_i  = 2'd1;
          cfg_level_i = 12'hFFF;
        end
        @(posedge sys_clk);
      end
    end
    $display("scenario %s k=%0d mode=%0d fire_window=%0d outputs=%0d", tag, k_cfg, mode, fire, nout);
  endtask

  initial begin
    int p;
    sys_rst_n = 1'b0;
    arm_i = 1'b0;
    ad_data_ch0_i = '0; ad_data_ch1_i = '0;
    cfg_log2_i = '0; cfg_mode_i = '0; cfg_trig_ch_i = 1'b0;
    cfg_level_i = '0; cfg_hyst_i = '0;
    #1;
    chk("rst_sample", 0, out_if.sample_o, 32'h0);
    chk("rst_vld",    0, 32'(out_if.sample_vld_o), 32'h0);
    chk("rst_trig",   0, 32'(out_if.triggered_o), 32'h0);
    chk("rst_state",  0, 32'(out_if.state_o), 32'h0);
    chk("rst_cnt",    0, 32'(out_if.sample_cnt_o), 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Immediate, k=0 ramp
    for (int i = 0; i < 1024; i++) begin
      in0[i] = 12'(i);
      in1[i] = 12'(4095 - i);
    end
    run_scen("imm_k0", 0, 0, 0, 0, 0, 40, -1);

    // Disarm mid-RUN: vld drops at the next edge and the state returns to IDLE
    arm_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      chk("disarm_vld",   i, 32'(out_if.sample_vld_o), 32'h0);
      chk("disarm_state", i, 32'(out_if.state_o), 32'h0);
    end

    // Reserved mode, k=2: 100s, 103s, then 1..4, then random
    for (int i = 0; i < 1024; i++) begin
      in0[i] = 12'($urandom);
      in1[i] = 12'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      in0[i]     = 12'd100;
      in0[i + 4] = 12'd103;
      in0[i + 8] = 12'(i + 1);
    end
    run_scen("rsvd_k2", 2, 3, 0, 0, 0, 64, -1);

    // Rising trigger on a triangle wave on ch1 starting upward from 2048
    for (int i = 0; i < 1024; i++) begin
      p = i % 400;
      if (p < 100)      in1[i] = 12'(2048 + 6 * p + $urandom_range(0, 3));
      else if (p < 300) in1[i] = 12'(2642 - 6 * (p - 100) + $urandom_range(0, 3));
      else              in1[i] = 12'(1442 + 6 * (p - 300) + $urandom_range(0, 3));
      in0[i] = 12'($urandom);
    end
    run_scen("rise_tri", 0, 1, 1, 2048, 100, 400, -1);

    // Falling trigger whose flag threshold saturates at 4095
    for (int i = 0; i < 1024; i++) begin
      if (i < 50)      in0[i] = 12'($urandom_range(3500, 4094));
      else if (i < 54) in0[i] = 12'hFFF;
      else             in0[i] = 12'($urandom_range(3900, 4095));
      in1[i] = 12'($urandom);
    end
    run_scen("fall_sat", 0, 2, 0, 4000, 500, 150, -1);

    // Rising trigger whose flag threshold saturates at 0
    for (int i = 0; i < 1024; i++) begin
      in0[i] = (i < 20) ? 12'($urandom_range(0, 3)) : 12'($urandom_range(0, 300));
      in1[i] = 12'($urandom);
    end
    run_scen("rise_sat0", 0, 1, 0, 50, 200, 80, -1);

    // Random data, decimated rising and falling triggers
    for (int i = 0; i < 1024; i++) begin
      in0[i] = 12'($urandom);
      in1[i] = 12'($urandom);
    end
    run_scen("rise_rand", 3, 1, 1, int'($urandom_range(1700, 2400)), int'($urandom_range(0, 300)), 400, -1);
    run_scen("fall_rand", 1, 2, 0, int'($urandom_range(1700, 2400)), int'($urandom_range(0, 600)), 300, -1);

    // Exponent above the maximum clamps to 256-sample windows
    run_scen("clamp_k12", 12, 0, 0, 0, 0, 600, -1);

    // Config change during RUN is ignored until re-armed
    run_scen("latch_k2", 2, 0, 0, 0, 0, 60, 20);
    run_scen("rearm_k4", 4, 0, 0, 0, 0, 80, -1);

    // Asynchronous reset in the middle of a window
    run_scen("pre_rst", 2, 0, 0, 0, 0, 10, -1);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    arm_i = 1'b0;
    #1;
    chk("midrst_sample", 0, out_if.sample_o, 32'h0);
    chk("midrst_vld",    0, 32'(out_if.sample_vld_o), 32'h0);
    chk("midrst_trig",   0, 32'(out_if.triggered_o), 32'h0);
    chk("midrst_state",  0, 32'(out_if.state_o), 32'h0);
    chk("midrst_cnt",    0, 32'(out_if.sample_cnt_o), 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk("postrst_vld",   i, 32'(out_if.sample_vld_o), 32'h0);
      chk("postrst_state", i, 32'(out_if.state_o), 32'h0);
    end
    run_scen("post_rst", 2, 0, 1, 0, 0, 40, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
